cla_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit lookahead slice. It accepts a full-width operand pair over a valid/ready handshake and feeds the slice one nibble per clock, least-significant nibble first, with the nibble carry registered between cycles. The full-width sum, carry-out and signed overflow are returned over a second valid/ready handshake. It sits directly upstream of the 4-bit `cla` slice, sequencing its operands and collecting its outputs, so wide arithmetic reuses one slice instead of WIDTH/4 copies.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_serial_adder_if.sv | 26 ++
 rtl/cla.sv | 26 ++
 rtl/cla_serial_adder.sv | 113 +++++++++++
 tb/tb_cla_serial_adder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and sizing helpers for the serial lookahead adder
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB = 4;

  function automatic int nslice(input int width);
    return width / NIB;
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// rtl/cla_serial_adder_if.sv - request/result handshake bundle for cla_serial_adder
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla.sv
// rtl/cla.sv - 4-bit carry-lookahead adder slice
module cla (
  input  logic x1, x2, x3, x4,
  input  logic y1, y2, y3, y4,
  input  logic cin,
  output logic z1, z2, z3, z4,
  output logic cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = {x4 & y4, x3 & y3, x2 & y2, x1 & y1};
  assign p = {x4 ^ y4, x3 ^ y3, x2 ^ y2, x1 ^ y1};

  // Every carry is a flat two-level function of cin, so depth stays constant.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign {z4, z3, z2, z1} = p ^ c[3:0];
  assign cout             = c[4];
endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - WIDTH-bit add/sub that streams nibbles through one cla slice
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  cla_serial_adder_if.slave bus
);
  localparam int             NSLICE = nslice(WIDTH);
  localparam int             KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(NSLICE - 1);
  localparam int             MSB    = WIDTH - 1;

  if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_width_check
    $error("cla_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB-1:0]   a_nib, b_nib, z_nib;
  logic             slice_cout;
  logic             in_ready_c, out_valid_c;

  assign a_nib = a_q[k_q*NIB +: NIB];
  assign b_nib = b_q[k_q*NIB +: NIB];

  cla u_cla (
    .x1  (a_nib[0]), .x2 (a_nib[1]), .x3 (a_nib[2]), .x4 (a_nib[3]),
    .y1  (b_nib[0]), .y2 (b_nib[1]), .y3 (b_nib[2]), .y4 (b_nib[3]),
    .cin (carry_q),
    .z1  (z_nib[0]), .z2 (z_nib[1]), .z3 (z_nib[2]), .z4 (z_nib[3]),
    .cout(slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is folded into the operands: invert B and force carry-in.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*NIB +: NIB] = z_nib;
        carry_d               = slice_cout;
        k_d                   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) & (z_nib[NIB-1] != a_q[MSB]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == IDLE) & ~rst;
    out_valid_c = (state_q == DONE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - randomized and directed bench for cla_serial_adder
module tb_cla_serial_adder;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cla_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic s, output logic [15:0] sum, output logic co,
                           output logic ov);
    int ua, ub, sa, sb, u, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      u  = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(ci);
      sr = sa + sb + int'(ci);
      co = (u > 65535);
    end
    sum = u[15:0];
    ov  = (sr > 32767) || (sr < -32768);
  endtask

  task automatic scramble();
    bus.in_valid = 1'($urandom);
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.cin      = 1'($urandom);
    bus.sub      = 1'($urandom);
  endtask

  // Called and returns on a falling edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input int stall);
    logic [15:0] e_sum;
    logic        e_co, e_ov;
    int          guard, lat;
    ref_model(a, b, ci, s, e_sum, e_co, e_ov);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.sub      = s;
    @(posedge clk);
    @(negedge clk);
    scramble();
    check("in_ready_run", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble();
    end
    check("latency", 32'(lat), 32'd4);
    check("sum", 32'(bus.sum), 32'(e_sum));
    check("cout", 32'(bus.cout), 32'(e_co));
    check("ovf", 32'(bus.ovf), 32'(e_ov));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      scramble();
      check("stall_sum", 32'(bus.sum), 32'(e_sum));
      check("stall_cout_ovf", 32'({bus.cout, bus.ovf}), 32'({e_co, e_ov}));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 5);
    run_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0);

    // Abort an operation after two nibbles have been written.
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
